cci_mpf_shim_buffer_rx: RTL and testbench

- QLP-side counterpart of the AFU Tx request buffer.
- Buffers read responses (channel 0 Rx) arriving from the QLP and presents them to a downstream shim through an explicit dequeue, making the Rx path latency insensitive.
- The CCI cannot back-pressure Rx, so the block reserves a buffer slot for every read request issued. It throttles the AFU through C0 almost-full when the slots are nearly exhausted.

---
 rtl/cci_mpf_shim_buffer_rx.sv | 99 +++++++++
 tb/tb_cci_mpf_shim_buffer_rx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_shim_buffer_rx.sv
// Channel 0 read-response buffer with credit-based throttling of the AFU.
// Define MPF_RX_BUF_BYPASS_EN to present a response in its arrival cycle when the FIFO is empty.
module cci_mpf_shim_buffer_rx #(
  parameter int CCI_DATA_WIDTH   = 512,
  parameter int CCI_RX_HDR_WIDTH = 18,
  parameter int N_ENTRIES        = 16,
  parameter int TX_THRESHOLD     = 4
) (
  input  logic                             clk,
  input  logic                             resetb,
  input  logic                             tx_rd_valid,
  input  logic                             tx_alm_full_in,
  output logic                             tx_alm_full_out,
  input  logic [CCI_RX_HDR_WIDTH-1:0]      rx_hdr,
  input  logic [CCI_DATA_WIDTH-1:0]        rx_data,
  input  logic                             rx_rd_valid,
  output logic [CCI_RX_HDR_WIDTH-1:0]      buf_hdr,
  output logic [CCI_DATA_WIDTH-1:0]        buf_data,
  output logic                             buf_valid,
  input  logic                             deq,
  output logic [$clog2(N_ENTRIES+1)-1:0]   credits,
  output logic                             err
);

  localparam int CW = $clog2(N_ENTRIES + 1);
  localparam int AW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int EW = CCI_RX_HDR_WIDTH + CCI_DATA_WIDTH;
  localparam logic [CW-1:0] MAX_CREDITS = CW'(N_ENTRIES);
  localparam logic [CW-1:0] THRESHOLD   = CW'(TX_THRESHOLD);
  localparam logic [AW-1:0] LAST_SLOT   = AW'(N_ENTRIES - 1);

  logic [EW-1:0] mem [N_ENTRIES];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] credits_next;
  logic          fifo_empty, fifo_full, bypass;
  logic          pop, push_req, push, drop, ret, cred_err;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == MAX_CREDITS);
`ifdef MPF_RX_BUF_BYPASS_EN
    bypass     = fifo_empty && rx_rd_valid;
`else
    bypass     = 1'b0;
`endif
    buf_valid  = !fifo_empty || bypass;
    {buf_hdr, buf_data} = bypass ? {rx_hdr, rx_data} : mem[rd_ptr];

    // A bypassed response consumed in its arrival cycle never occupies a slot
    pop      = deq && !fifo_empty;
    ret      = deq && buf_valid;
    push_req = rx_rd_valid && !(bypass && deq);
    push     = push_req && (!fifo_full || pop);
    drop     = push_req && fifo_full && !pop;

    credits_next = credits;
    cred_err     = 1'b0;
    if (tx_rd_valid && !ret) begin
      if (credits == '0) cred_err = 1'b1;
      else               credits_next = credits - 1'b1;
    end else if (ret && !tx_rd_valid) begin
      if (credits == MAX_CREDITS) cred_err = 1'b1;
      else                        credits_next = credits + 1'b1;
    end
  end

  // Held high through reset so the AFU cannot issue before credits exist
  assign tx_alm_full_out = !resetb || tx_alm_full_in || (credits <= THRESHOLD);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      credits <= MAX_CREDITS;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      err     <= 1'b0;
    end else begin
      credits <= credits_next;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (cred_err || drop) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {rx_hdr, rx_data};
  end

endmodule

// File: tb/tb_cci_mpf_shim_buffer_rx.sv
// Self-checking bench for cci_mpf_shim_buffer_rx using a queue-based reference model.
module tb_cci_mpf_shim_buffer_rx;

  localparam int DW  = 512;
  localparam int HW  = 18;
  localparam int N   = 16;
  localparam int THR = 4;
`ifdef MPF_RX_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          tx_rd_valid = 1'b0;
  logic          tx_alm_full_in = 1'b0;
  logic          rx_rd_valid = 1'b0;
  logic          deq = 1'b0;
  logic [HW-1:0] rx_hdr = '0;
  logic [DW-1:0] rx_data = '0;
  logic          tx_alm_full_out, buf_valid, err;
  logic [HW-1:0] buf_hdr;
  logic [DW-1:0] buf_data;
  logic [$clog2(N+1)-1:0] credits;

  int vectors = 0;
  int miscompares = 0;

  int                  m_credits;
  bit                  m_err;
  logic [HW+DW-1:0]    m_q[$];

  cci_mpf_shim_buffer_rx #(
    .CCI_DATA_WIDTH(DW), .CCI_RX_HDR_WIDTH(HW), .N_ENTRIES(N), .TX_THRESHOLD(THR)
  ) dut (
    .clk(clk), .resetb(resetb), .tx_rd_valid(tx_rd_valid),
    .tx_alm_full_in(tx_alm_full_in), .tx_alm_full_out(tx_alm_full_out),
    .rx_hdr(rx_hdr), .rx_data(rx_data), .rx_rd_valid(rx_rd_valid),
    .buf_hdr(buf_hdr), .buf_data(buf_data), .buf_valid(buf_valid),
    .deq(deq), .credits(credits), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] randData();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic cmp(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow from the model state plus the inputs currently driven
  task automatic checkOutput();
    logic             ev;
    logic [HW+DW-1:0] eh;
    ev = (m_q.size() > 0) || (BYP && rx_rd_valid && resetb);
    eh = (m_q.size() > 0) ? m_q[0] : {rx_hdr, rx_data};
    cmp("credits",   DW'(credits), DW'(m_credits));
    cmp("alm_full",  DW'(tx_alm_full_out), DW'(!resetb || tx_alm_full_in || (m_credits <= THR)));
    cmp("buf_valid", DW'(buf_valid), DW'(ev));
    cmp("err",       DW'(err), DW'(m_err));
    if (ev) begin
      cmp("buf_hdr",  DW'(buf_hdr), DW'(eh[HW+DW-1:DW]));
      cmp("buf_data", buf_data, eh[DW-1:0]);
    end
  endtask

  task automatic modelStep();
    bit ev, byp_take, pop, ret;
    ev       = (m_q.size() > 0) || (BYP && rx_rd_valid);
    byp_take = BYP && (m_q.size() == 0) && rx_rd_valid && deq;
    pop      = deq && (m_q.size() > 0);
    ret      = deq && ev;
    if (tx_rd_valid && !ret) begin
      if (m_credits == 0) m_err = 1'b1;
      else m_credits--;
    end else if (ret && !tx_rd_valid) begin
      if (m_credits == N) m_err = 1'b1;
      else m_credits++;
    end
    if (pop) void'(m_q.pop_front());
    if (rx_rd_valid && !byp_take) begin
      if (m_q.size() == N) m_err = 1'b1;
      else m_q.push_back({rx_hdr, rx_data});
    end
  endtask

  task automatic applyStimulus(input bit tx, input bit rxv, input logic [HW-1:0] hdr,
                               input bit d, input bit alm);
    @(negedge clk);
    tx_rd_valid    = tx;
    rx_rd_valid    = rxv;
    rx_hdr         = hdr;
    rx_data        = randData();
    deq            = d;
    tx_alm_full_in = alm;
    #1;
    checkOutput();
    modelStep();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    @(negedge clk);
    resetb = 1'b0;
    tx_rd_valid = 1'b0; rx_rd_valid = 1'b0; deq = 1'b0; tx_alm_full_in = 1'b0;
    m_q.delete();
    m_credits = N;
    m_err = 1'b0;
    #1;
    checkOutput();
    @(negedge clk);
    resetb = 1'b1;
  endtask

  initial begin
    int outstanding;

    // Reset values, then throttling as credits drain
    doReset();
    idle();
    repeat (12) applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    idle();
    repeat (4) applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    idle();

    // Underflow is sticky; returns still count afterwards
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    idle();
    repeat (3) applyStimulus(1'b0, 1'b1, HW'($urandom), 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle();
    repeat (13) applyStimulus(1'b0, 1'b1, HW'($urandom), 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle();

    // Ordered stream with deq held high
    doReset();
    repeat (4) applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int h = 1; h <= 4; h++) applyStimulus(1'b0, 1'b1, HW'(h), 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle();

    // Full FIFO: simultaneous enq/deq, then a dropped response
    repeat (16) applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    repeat (16) applyStimulus(1'b0, 1'b1, HW'($urandom), 1'b0, 1'b0);
    idle();
    applyStimulus(1'b0, 1'b1, HW'($urandom), 1'b1, 1'b0);
    idle();
    applyStimulus(1'b0, 1'b1, HW'($urandom), 1'b0, 1'b0);
    idle();

    // Empty FIFO with response and deq in the same cycle
    doReset();
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, HW'($urandom), 1'b1, 1'b0);
    idle();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle();

    // Random protocol-respecting traffic with a reset in the middle
    doReset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) doReset();
      outstanding = N - m_credits - m_q.size();
      applyStimulus((m_credits > 0) && ($urandom_range(0, 1) == 1),
                    (outstanding > 0) && ($urandom_range(0, 2) != 0),
                    HW'($urandom),
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7) == 0);
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
